// File: rtl/neuron_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac_acc
// Serial signed multiply-accumulate with bias, saturation, optional ReLU and a
// valid/ready result port.
// Revision : 1.0
// ============================================================================
module neuron_mac_acc #(
  parameter int DW        = 8,
  parameter int ACC_W     = 21,
  parameter int MAX_TERMS = 32,
  parameter int LEN_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [DW-1:0]    bias,
  input  logic             relu_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    x,
  input  logic [DW-1:0]    w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             sat_flag
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_len;
  logic              r_relu;
  logic              r_sat;
  logic [ACC_W-1:0]  r_acc_out;

  logic                    w_fire;
  logic                    w_last;
  logic signed [2*DW-1:0]  w_prod;
  logic [ACC_W:0]          w_sum;
  logic                    w_ovf;
  logic [ACC_W-1:0]        w_acc_sat;
  logic [ACC_W-1:0]        w_bias_ext;
  logic [CNT_W-1:0]        w_len_eff;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [ACC_W-1:0]        w_res_src;
  logic                    w_relu_src;
  logic [ACC_W-1:0]        w_res;

  assign w_fire     = (r_state == S_RUN) && in_valid;
  assign w_prod     = $signed(x) * $signed(w);
  // One guard bit above the accumulator exposes overflow as a sign disagreement.
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + (ACC_W+1)'(w_prod);
  assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_sat  = w_ovf ? (w_sum[ACC_W] ? c_acc_min : c_acc_max) : w_sum[ACC_W-1:0];
  assign w_bias_ext = ACC_W'($signed(bias));
  assign w_len_eff  = (32'(len) > 32'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : CNT_W'(len);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_last     = w_fire && (w_cnt_inc == r_len);

  // The result is captured on entry to DONE: from the bias when len is zero,
  // otherwise from the final saturated sum.
  assign w_res_src  = (r_state == S_IDLE) ? w_bias_ext : w_acc_sat;
  assign w_relu_src = (r_state == S_IDLE) ? relu_en : r_relu;
  assign w_res      = (w_relu_src && w_res_src[ACC_W-1]) ? '0 : w_res_src;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = (w_len_eff != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_relu    <= 1'b0;
      r_sat     <= 1'b0;
      r_acc_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= w_bias_ext;
            r_cnt  <= '0;
            r_len  <= w_len_eff;
            r_relu <= relu_en;
            r_sat  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            r_acc <= w_acc_sat;
            r_cnt <= w_cnt_inc;
            if (w_ovf) r_sat <= 1'b1;
          end
        end
        default: ;
      endcase
      if (w_state_nxt == S_DONE && r_state != S_DONE) r_acc_out <= w_res;
    end
  end

  assign acc_out  = r_acc_out;
  assign sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_acc.sv
`default_nettype none
// Randomised bench: a default instance and an ACC_W=16 instance share stimulus
// and are checked against a saturating arithmetic reference model.
module tb_neuron_mac_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [5:0]  len = '0;
  logic [7:0]  bias = '0;
  logic [7:0]  x = '0;
  logic [7:0]  w = '0;

  logic        a_in_ready, a_out_valid, a_busy, a_sat;
  logic [20:0] a_acc;
  logic        b_in_ready, b_out_valid, b_busy, b_sat;
  logic [15:0] b_acc;

  int n_vec = 0;
  int n_err = 0;
  int px[$], pw[$], ax[$], aw[$];

  always #5 clk = ~clk;

  neuron_mac_acc u_dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(a_in_ready), .x(x), .w(w),
    .out_valid(a_out_valid), .out_ready(out_ready), .acc_out(a_acc),
    .busy(a_busy), .sat_flag(a_sat)
  );

  neuron_mac_acc #(.ACC_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(b_in_ready), .x(x), .w(w),
    .out_valid(b_out_valid), .out_ready(out_ready), .acc_out(b_acc),
    .busy(b_busy), .sat_flag(b_sat)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Sum of bias and accepted products, clamped to the signed range after each term.
  function automatic longint model(input int width, input int b, input bit relu, output bit sat);
    longint mx, mn, a;
    mx  = (longint'(1) << (width - 1)) - 1;
    mn  = -(longint'(1) << (width - 1));
    a   = b;
    sat = 1'b0;
    foreach (ax[i]) begin
      a = a + longint'(ax[i]) * longint'(aw[i]);
      if (a > mx) begin a = mx; sat = 1'b1; end
      else if (a < mn) begin a = mn; sat = 1'b1; end
    end
    return (relu && a < 0) ? 0 : a;
  endfunction

  function automatic int rnd8();
    if ($urandom_range(3) == 0) return ($urandom_range(1) == 1) ? 127 : -128;
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic fill(input int n);
    px.delete();
    pw.delete();
    for (int i = 0; i < n; i++) begin
      px.push_back(rnd8());
      pw.push_back(rnd8());
    end
  endtask

  task automatic eval(input int l, input int b, input bit relu, input int gap_pct,
                      input int hold, input bit pulse);
    int     n_eff, cyc, idx;
    longint r_a, r_b;
    bit     s_a, s_b;
    n_eff = (l > 32) ? 32 : l;
    ax.delete();
    aw.delete();
    len = 6'(l); bias = 8'(b); relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start_a", a_busy, 1);
    chk("busy_after_start_b", b_busy, 1);
    chk("sat_cleared_a", a_sat, 0);
    chk("sat_cleared_b", b_sat, 0);

    cyc = 0;
    while (ax.size() < n_eff && cyc < 500) begin
      idx = ax.size();
      in_valid = ($urandom_range(99) >= gap_pct);
      x = 8'(px[idx]);
      w = 8'(pw[idx]);
      @(negedge clk);
      chk("in_ready_run_a", a_in_ready, 1);
      chk("in_ready_run_b", b_in_ready, 1);
      if (in_valid) begin
        ax.push_back(px[idx]);
        aw.push_back(pw[idx]);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 500) chk("run_timeout", cyc, 0);

    // Keep offering pairs; none may be consumed once the term count is reached.
    in_valid = 1'b1;
    x = 8'(rnd8());
    w = 8'(rnd8());
    r_a = model(21, b, relu, s_a);
    r_b = model(16, b, relu, s_b);

    for (int h = 0; h < hold; h++) begin
      start = pulse && (h == 1);
      @(negedge clk);
      chk("out_valid_hold_a", a_out_valid, 1);
      chk("out_valid_hold_b", b_out_valid, 1);
      chk("acc_hold_a", longint'($signed(a_acc)), r_a);
      chk("acc_hold_b", longint'($signed(b_acc)), r_b);
      chk("in_ready_done_a", a_in_ready, 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_a", a_out_valid, 1);
    chk("out_valid_b", b_out_valid, 1);
    chk("acc_out_a", longint'($signed(a_acc)), r_a);
    chk("acc_out_b", longint'($signed(b_acc)), r_b);
    chk("sat_a", a_sat, s_a);
    chk("sat_b", b_sat, s_b);
    chk("in_ready_done_b", b_in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_drop_a", a_out_valid, 0);
    chk("idle_busy_a", a_busy, 0);
    chk("idle_busy_b", b_busy, 0);
    chk("acc_kept_a", longint'($signed(a_acc)), r_a);
    chk("acc_kept_b", longint'($signed(b_acc)), r_b);
    chk("sat_sticky_b", b_sat, s_b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_acc", a_acc, 0);
    chk("rst_sat", a_sat, 0);
    rst = 1'b0;

    px = '{2, -4, 10};  pw = '{3, 5, 10};
    eval(3, 5, 1'b0, 0, 0, 1'b0);
    px = '{-128};       pw = '{127};
    eval(1, 0, 1'b0, 0, 0, 1'b0);
    eval(1, 0, 1'b1, 0, 1, 1'b0);
    fill(4);
    eval(4, rnd8(), 1'b0, 50, 5, 1'b1);
    px.delete();        pw.delete();
    eval(0, -7, 1'b0, 0, 1, 1'b0);
    fill(40);
    eval(40, rnd8(), 1'b0, 0, 2, 1'b0);
    px = '{-128, -128}; pw = '{-128, -128};
    eval(2, 0, 1'b0, 0, 1, 1'b0);

    // Abort an evaluation part way through with reset.
    len = 6'd5; bias = 8'd3; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x = 8'(rnd8());
      w = 8'(rnd8());
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy_a", a_busy, 0);
    chk("midrst_busy_b", b_busy, 0);
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_in_ready", a_in_ready, 0);
    chk("midrst_acc_a", a_acc, 0);
    chk("midrst_acc_b", b_acc, 0);
    fill(5);
    eval(5, rnd8(), 1'b0, 20, 1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      int l;
      l = int'($urandom_range(40));
      fill(l);
      eval(l, rnd8(), 1'($urandom_range(1)), int'($urandom_range(60)),
           int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
